// File: rtl/particle_weigher_if.sv
// Shared particle/grid types and the particle-in / beat-out handshake bundle
// between the particle source, the weigher and the charge-accumulation stage.
package defs;
    localparam int PFRAC          = 12;
    localparam int PWHOLE         = 6;
    localparam int VPERPWIDTH     = 14;
    localparam int GRID_ADDRWIDTH = 12;
    localparam int PSIZE          = 50;
    localparam int NUM_PARTICLES  = 16384;

    typedef logic [PWHOLE+PFRAC-1:0]   pos_t;
    typedef logic [VPERPWIDTH-1:0]     vperp_t;
    typedef logic [GRID_ADDRWIDTH-1:0] addr_t;
    typedef logic [2*PFRAC-1:0]        coeff_t;

    typedef struct packed {
        pos_t   y;
        pos_t   x;
        vperp_t vperp;
    } particle_t;
endpackage

interface particle_weigher_if #(
    parameter int PCNT_WIDTH = 15
);
    import defs::*;

    logic                  in_valid;
    logic                  in_ready;
    particle_t             in_particle;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    addr_t                 out_addr;
    coeff_t                out_weight;
    vperp_t                out_vperp;
    logic [1:0]            out_corner;
    logic                  out_last;
    logic [PCNT_WIDTH-1:0] particle_count;

    modport slave (
        input  in_valid, in_particle, in_last, out_ready,
        output in_ready, out_valid, out_addr, out_weight, out_vperp,
               out_corner, out_last, particle_count
    );

    modport master (
        output in_valid, in_particle, in_last, out_ready,
        input  in_ready, out_valid, out_addr, out_weight, out_vperp,
               out_corner, out_last, particle_count
    );
endinterface

// File: rtl/particle_weigher.sv
// Bilinear area weighting of one particle onto its four surrounding points of
// a periodic 64x64 grid, emitted as four (address, weight, vperp) beats.
module particle_weigher
    import defs::*;
#(
    parameter int PCNT_WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst,
    particle_weigher_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

    state_t                state_q;
    particle_t             part_q;
    logic                  last_q;
    coeff_t                w_q [4];
    logic [1:0]            corner_q;
    logic                  out_valid_q;
    addr_t                 out_addr_q;
    coeff_t                out_weight_q;
    vperp_t                out_vperp_q;
    logic                  out_last_q;
    logic [PCNT_WIDTH-1:0] cnt_q;

    // Only the dx = dy = 0 corner-0 product (4096*4096) overflows 24 bits.
    function automatic coeff_t sat24(input logic [25:0] p);
        return (|p[25:24]) ? '1 : p[23:0];
    endfunction

    // Whole-cell +1 wraps naturally in 6 bits, giving the periodic grid.
    function automatic addr_t corner_addr(input logic [1:0] c, input particle_t p);
        logic [PWHOLE-1:0] xw;
        logic [PWHOLE-1:0] yw;
        xw = p.x[PWHOLE+PFRAC-1:PFRAC] + {5'd0, c[0]};
        yw = p.y[PWHOLE+PFRAC-1:PFRAC] + {5'd0, c[1]};
        return {yw, xw};
    endfunction

    logic [12:0] wx0_d, wx1_d, wy0_d, wy1_d;
    logic [25:0] p_d [4];
    coeff_t      w_d [4];
    logic [1:0]  corner_nxt_d;

    assign wx1_d = {1'b0, part_q.x[PFRAC-1:0]};
    assign wy1_d = {1'b0, part_q.y[PFRAC-1:0]};
    assign wx0_d = 13'd4096 - wx1_d;
    assign wy0_d = 13'd4096 - wy1_d;

    assign p_d[0] = {13'd0, wy0_d} * {13'd0, wx0_d};
    assign p_d[1] = {13'd0, wy0_d} * {13'd0, wx1_d};
    assign p_d[2] = {13'd0, wy1_d} * {13'd0, wx0_d};
    assign p_d[3] = {13'd0, wy1_d} * {13'd0, wx1_d};

    always_comb begin
        for (int i = 0; i < 4; i++) w_d[i] = sat24(p_d[i]);
    end

    assign corner_nxt_d = corner_q + 2'd1;

    assign bus.in_ready = (state_q == IDLE) ||
                          (state_q == EMIT && corner_q == 2'd3 && bus.out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            part_q       <= '0;
            last_q       <= 1'b0;
            for (int i = 0; i < 4; i++) w_q[i] <= '0;
            corner_q     <= 2'd0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_weight_q <= '0;
            out_vperp_q  <= '0;
            out_last_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        part_q  <= bus.in_particle;
                        last_q  <= bus.in_last;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
                    corner_q     <= 2'd0;
                    out_valid_q  <= 1'b1;
                    out_addr_q   <= corner_addr(2'd0, part_q);
                    out_weight_q <= w_d[0];
                    out_vperp_q  <= part_q.vperp;
                    out_last_q   <= 1'b0;
                    state_q      <= EMIT;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (corner_q != 2'd3) begin
                            corner_q     <= corner_nxt_d;
                            out_addr_q   <= corner_addr(corner_nxt_d, part_q);
                            out_weight_q <= w_q[corner_nxt_d];
                            out_last_q   <= last_q && (corner_nxt_d == 2'd3);
                        end else begin
                            cnt_q       <= cnt_q + 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            // Back-to-back: next particle is taken on the final beat.
                            if (bus.in_valid) begin
                                part_q  <= bus.in_particle;
                                last_q  <= bus.in_last;
                                state_q <= CALC;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_addr       = out_addr_q;
    assign bus.out_weight     = out_weight_q;
    assign bus.out_vperp      = out_vperp_q;
    assign bus.out_corner     = corner_q;
    assign bus.out_last       = out_last_q;
    assign bus.particle_count = cnt_q;

endmodule

// File: tb/tb_particle_weigher.sv
// Directed and randomized checks of particle_weigher against a scoreboard of
// expected beats computed from plain bilinear-weight arithmetic.
module tb_particle_weigher;
    import defs::*;

    localparam int N = 16384;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    particle_weigher_if #(.PCNT_WIDTH(15)) bus ();

    particle_weigher #(.PCNT_WIDTH(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned addr;
        int unsigned weight;
        int unsigned vperp;
        int unsigned corner;
        bit          last;
        int unsigned sum_exp;
    } beat_t;

    typedef struct {
        int unsigned addr;
        int unsigned weight;
    } obs_t;

    beat_t exp_q[$];
    obs_t  obs_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    in_hs, out_hs;
    int unsigned wsum = 0;
    int    last_seen = 0;

    int unsigned int_addr[4] = '{645, 646, 709, 710};
    int unsigned int_w[4]    = '{32'h600000, 32'h200000, 32'h600000, 32'h200000};
    int unsigned wrap_addr[4] = '{4095, 4032, 63, 0};
    int unsigned sat_w[4]    = '{32'hFFFFFF, 0, 0, 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic particle_t mk(input int xw, input int xf, input int yw, input int yf,
                                     input int vp);
        particle_t p;
        p.x     = pos_t'((xw << 12) | xf);
        p.y     = pos_t'((yw << 12) | yf);
        p.vperp = vperp_t'(vp);
        return p;
    endfunction

    function automatic particle_t rnd_particle();
        particle_t p;
        p.x     = pos_t'($urandom);
        p.y     = pos_t'($urandom);
        p.vperp = vperp_t'($urandom);
        if ($urandom_range(0, 15) == 0) begin
            p.x[11:0] = '0;
            p.y[11:0] = '0;
        end
        return p;
    endfunction

    // Reference: area weights (4096-d or d per axis), product capped at 2^24-1.
    task automatic push_particle(input particle_t p, input logic il);
        int unsigned xw, yw, dx, dy, wx, wy;
        longint unsigned prod;
        beat_t b;
        xw = p.x / 4096; dx = p.x % 4096;
        yw = p.y / 4096; dy = p.y % 4096;
        for (int c = 0; c < 4; c++) begin
            wx = (c % 2 == 1) ? dx : 4096 - dx;
            wy = (c / 2 == 1) ? dy : 4096 - dy;
            prod = longint'(wx) * longint'(wy);
            b.addr    = ((yw + c / 2) % 64) * 64 + (xw + c % 2) % 64;
            b.weight  = (prod >= 64'd16777216) ? 32'hFFFFFF : int'(prod);
            b.vperp   = p.vperp;
            b.corner  = c;
            b.last    = il && (c == 3);
            b.sum_exp = (dx == 0 && dy == 0) ? 16777215 : 16777216;
            exp_q.push_back(b);
        end
    endtask

    task automatic score_beat();
        beat_t e;
        obs_t  o;
        o.addr = bus.out_addr; o.weight = bus.out_weight;
        obs_q.push_back(o);
        if (bus.out_last) last_seen++;
        if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("addr",   bus.out_addr,   e.addr);
        check("weight", bus.out_weight, e.weight);
        check("vperp",  bus.out_vperp,  e.vperp);
        check("corner", bus.out_corner, e.corner);
        check("last",   bus.out_last,   e.last);
        wsum += bus.out_weight;
        if (e.corner == 3) begin
            check("weight_sum", wsum, e.sum_exp);
            wsum = 0;
        end
    endtask

    task automatic drive_cycle(input logic iv, input particle_t p, input logic il,
                               input logic ordy);
        bus.in_valid = iv; bus.in_particle = p; bus.in_last = il; bus.out_ready = ordy;
        #1;
        in_hs  = bus.in_valid && bus.in_ready;
        out_hs = bus.out_valid && bus.out_ready;
        if (out_hs) score_beat();
        if (in_hs) push_particle(p, il);
        @(posedge clk); #1;
    endtask

    task automatic run_single(input particle_t p);
        obs_q.delete();
        wsum = 0;
        drive_cycle(1'b1, p, 1'b0, 1'b1);
        check("single_accept", in_hs, 1);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("single_drained", exp_q.size(), 0);
    endtask

    particle_t cur, pa, pb;
    logic [63:0] snap;
    int idx, cyc, stale;

    initial begin
        bus.in_valid = 0; bus.in_particle = '0; bus.in_last = 0; bus.out_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_count", bus.particle_count, 0);
        check("rst_outputs", {bus.out_addr, bus.out_weight, bus.out_vperp, bus.out_corner,
                              bus.out_last}, 0);
        rst = 1'b0;

        // Interior point with latency check.
        obs_q.delete();
        pa = mk(5, 12'h400, 10, 12'h800, 14'h1234);
        drive_cycle(1'b1, pa, 1'b0, 1'b1);
        check("int_accept", in_hs, 1);
        check("int_calc_no_valid", bus.out_valid, 0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("int_first_valid", bus.out_valid, 1);
        check("int_first_corner", bus.out_corner, 0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("int_beats", obs_q.size(), 4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            check("int_addr", obs_q[i].addr, int_addr[i]);
            check("int_weight", obs_q[i].weight, int_w[i]);
        end
        check("int_count", bus.particle_count, 1);
        check("int_idle_ready", bus.in_ready, 1);

        // Periodic wrap at the grid corner.
        run_single(mk(63, 12'h800, 63, 12'h800, 14'h0AAA));
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            check("wrap_addr", obs_q[i].addr, wrap_addr[i]);
            check("wrap_weight", obs_q[i].weight, 32'h400000);
        end

        // Saturated corner-0 weight.
        run_single(mk(7, 0, 7, 0, 14'h3FFF));
        check("sat_addr0", obs_q.size() > 0 ? obs_q[0].addr : 0, 455);
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            check("sat_weight", obs_q[i].weight, sat_w[i]);
        check("sat_count", bus.particle_count, 3);

        // Back-pressure on corner 1 with a second particle queued.
        pa = rnd_particle();
        pb = rnd_particle();
        drive_cycle(1'b1, pa, 1'b0, 1'b1);
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("bp_corner1", bus.out_corner, 1);
        snap = {bus.out_addr, bus.out_weight, bus.out_vperp, bus.out_corner};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, pb, 1'b0, 1'b0);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_valid_held", bus.out_valid, 1);
            check("bp_stable", {bus.out_addr, bus.out_weight, bus.out_vperp, bus.out_corner},
                  snap);
        end
        drive_cycle(1'b1, pb, 1'b0, 1'b1);
        drive_cycle(1'b1, pb, 1'b0, 1'b1);
        check("bp_corner3", bus.out_corner, 3);
        drive_cycle(1'b1, pb, 1'b0, 1'b1);
        check("bp_queued_accept", in_hs, 1);
        check("bp_calc_no_valid", bus.out_valid, 0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("bp_next_valid", bus.out_valid, 1);
        check("bp_next_vperp", bus.out_vperp, pb.vperp);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("bp_drained", exp_q.size(), 0);
        check("bp_count", bus.particle_count, 5);

        // Asynchronous reset while corner 2 is presented.
        drive_cycle(1'b1, rnd_particle(), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("rst_mid_corner2", bus.out_corner, 2);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_count", bus.particle_count, 0);
        check("rst_mid_ready", bus.in_ready, 1);
        exp_q.delete();
        wsum = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b1);
            if (bus.out_valid) stale++;
        end
        check("rst_no_stale", stale, 0);

        // Full random stream at maximum throughput.
        last_seen = 0;
        idx = 0;
        cyc = 0;
        cur = rnd_particle();
        while (int'(bus.particle_count) != N && cyc < 90000) begin
            drive_cycle(idx < N, cur, idx == N - 1, 1'b1);
            if (in_hs) begin
                idx++;
                cur = rnd_particle();
            end
            cyc++;
        end
        check("stream_count", bus.particle_count, N);
        check("stream_accepted", idx, N);
        check("stream_drained", exp_q.size(), 0);
        check("stream_last_once", last_seen, 1);
        check("stream_throughput", cyc <= 5 * N + 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
